// File: rtl/cpu_cfg_responder_pkg.sv
// Shared types for the CPU configuration bus responder: cell config entry,
// bus-mode encodings, responder FSM states and the bus request decode.
package cpu_cfg_responder_pkg;

  typedef struct packed {
    logic [3:0]  FWD;
    logic [11:0] VPI;
  } CellCfgType;

  localparam logic BUS_STROBE = 1'b0;
  localparam logic BUS_DSTACK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } rsp_state_t;

  // Strobe mode: either strobe low requests. Data-strobe mode: DS low requests.
  function automatic logic bus_request(input logic mode, input logic sel,
                                       input logic rd_ds, input logic wr_rw);
    if (mode == BUS_DSTACK) return !sel && !rd_ds;
    return !sel && (!rd_ds || !wr_rw);
  endfunction

endpackage

// File: rtl/cpu_cfg_table.sv
// Configuration table: flop array with async clear, one CPU write port,
// a combinational CPU read port and a registered core lookup port.
module cpu_cfg_table
  import cpu_cfg_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  CellCfgType        wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output CellCfgType        rd_data,
  input  logic [ADDR_W-1:0] lookup_idx,
  output CellCfgType        lookup_cfg
);

  localparam int DEPTH = 1 << ADDR_W;

  CellCfgType mem [DEPTH];

  // NOTE: the array is built from resettable flops (not a RAM macro) because
  // every entry must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Reads the pre-edge contents, so a same-edge write shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lookup_cfg <= '0;
    else        lookup_cfg <= mem[lookup_idx];
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cpu_cfg_responder.sv
// CPU configuration bus responder (strobe / data-strobe modes) in front of
// cpu_cfg_table. Optional macro CPU_CFG_SYNC_EN adds input synchronisers.
module cpu_cfg_responder
  import cpu_cfg_responder_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BusMode,
  input  logic [23:0]       Addr,
  input  logic              Sel,
  input  logic [15:0]       DataIn,
  output logic [15:0]       DataOut,
  input  logic              Rd_DS,
  input  logic              Wr_RW,
  output logic              Rdy_Dtack,
  input  logic [ADDR_W-1:0] lookup_idx,
  output logic [15:0]       lookup_cfg
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic sel_s, rd_s, wr_s;

`ifdef CPU_CFG_SYNC_EN
  logic [1:0] sel_q, rd_q, wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 2'b11;
      rd_q  <= 2'b11;
      wr_q  <= 2'b11;
    end else begin
      sel_q <= {sel_q[0], Sel};
      rd_q  <= {rd_q[0], Rd_DS};
      wr_q  <= {wr_q[0], Wr_RW};
    end
  end

  assign sel_s = sel_q[1];
  assign rd_s  = rd_q[1];
  assign wr_s  = wr_q[1];
`else
  assign sel_s = Sel;
  assign rd_s  = Rd_DS;
  assign wr_s  = Wr_RW;
`endif

  rsp_state_t  state, nxt_state;
  logic [3:0]  cnt;
  logic        mode_q, write_q;
  logic [23:0] addr_q;
  CellCfgType  data_q;
  logic        live_req, held_req, accept, commit, hit, ack, mode_eff;
  CellCfgType  rd_data, lookup_data;

  assign live_req = bus_request(BusMode, sel_s, rd_s, wr_s);
  assign held_req = bus_request(mode_q, sel_s, rd_s, wr_s);
  assign hit      = (addr_q[23:ADDR_W] == BASE_ADDR[23:ADDR_W]);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      ST_IDLE: if (live_req) begin
        nxt_state = ST_WAIT;
        accept    = 1'b1;
      end
      ST_WAIT: if (cnt == 4'd0) begin
        nxt_state = ST_ACK;
        commit    = 1'b1;
      end
      ST_ACK:  if (!held_req) nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      mode_q  <= BUS_STROBE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      DataOut <= '0;
    end else begin
      if (accept) begin
        cnt     <= WAIT_INIT;
        mode_q  <= BusMode;
        write_q <= !wr_s;  // write strobe low (mode 0) or RW=0 (mode 1)
        addr_q  <= Addr;
        data_q  <= CellCfgType'(DataIn);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !write_q) DataOut <= hit ? rd_data : '0;
    end
  end

  cpu_cfg_table #(.ADDR_W(ADDR_W)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (commit && write_q && hit),
    .wr_idx     (addr_q[ADDR_W-1:0]),
    .wr_data    (data_q),
    .rd_idx     (addr_q[ADDR_W-1:0]),
    .rd_data    (rd_data),
    .lookup_idx (lookup_idx),
    .lookup_cfg (lookup_data)
  );

  assign lookup_cfg = lookup_data;

  // Idle follows the live mode pin so the pin always shows its inactive level.
  assign ack       = (state == ST_ACK);
  assign mode_eff  = (state == ST_IDLE) ? BusMode : mode_q;
  assign Rdy_Dtack = (mode_eff == BUS_DSTACK) ? ~ack : ack;

endmodule

// File: tb/tb_cpu_cfg_responder.sv
// Directed self-checking bench for cpu_cfg_responder (default parameters);
// latencies adapt when CPU_CFG_SYNC_EN is defined.
module tb_cpu_cfg_responder;

  localparam int WS = 1;
`ifdef CPU_CFG_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Negedges from driving a request to first seeing acknowledge / its release.
  localparam int ACK_EDGES = 2 + WS + SYNC_LAT;
  localparam int REL_EDGES = 1 + SYNC_LAT;
  localparam int LIMIT     = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        BusMode;
  logic [23:0] Addr;
  logic        Sel;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Rd_DS;
  logic        Wr_RW;
  logic        Rdy_Dtack;
  logic [7:0]  lookup_idx;
  logic [15:0] lookup_cfg;

  int checks = 0;
  int passed = 0;

  cpu_cfg_responder #(.ADDR_W(8), .BASE_ADDR(24'h000000), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BusMode    (BusMode),
    .Addr       (Addr),
    .Sel        (Sel),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .Rd_DS      (Rd_DS),
    .Wr_RW      (Wr_RW),
    .Rdy_Dtack  (Rdy_Dtack),
    .lookup_idx (lookup_idx),
    .lookup_cfg (lookup_cfg)
  );

  always #5 clk = ~clk;

  function automatic logic ack_seen();
    return (BusMode == 1'b1) ? !Rdy_Dtack : Rdy_Dtack;
  endfunction

  task automatic start_access(input logic mode, input logic wr,
                              input logic [23:0] a, input logic [15:0] d);
    @(negedge clk);
    BusMode = mode;
    Addr    = a;
    DataIn  = d;
    Sel     = 1'b0;
    Rd_DS   = (mode == 1'b0) ? wr : 1'b0;
    Wr_RW   = !wr;
  endtask

  task automatic wait_ack(output int edges);
    edges = -1;
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge clk);
      if (ack_seen()) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic release_bus(output int edges);
    Sel   = 1'b1;
    Rd_DS = 1'b1;
    Wr_RW = 1'b1;
    edges = -1;
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge clk);
      if (!ack_seen()) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic do_access(input logic mode, input logic wr, input logic [23:0] a,
                           input logic [15:0] d, output logic [15:0] rdata,
                           output int ack_edges, output int rel_edges);
    start_access(mode, wr, a, d);
    wait_ack(ack_edges);
    rdata = DataOut;
    release_bus(rel_edges);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; BusMode = 1'b0; Addr = '0; Sel = 1'b1; DataIn = '0;
    Rd_DS = 1'b1; Wr_RW = 1'b1; lookup_idx = 8'd5;
    #3;
    checks++; if (Rdy_Dtack !== 1'b0) $display("FAIL reset_rdy_mode0 got %b exp 0", Rdy_Dtack); else passed++;
    checks++; if (DataOut !== 16'h0000) $display("FAIL reset_dataout got %h exp 0000", DataOut); else passed++;
    checks++; if (lookup_cfg !== 16'h0000) $display("FAIL reset_lookup got %h exp 0000", lookup_cfg); else passed++;
    BusMode = 1'b1;
    #1;
    checks++; if (Rdy_Dtack !== 1'b1) $display("FAIL reset_dtack_mode1 got %b exp 1", Rdy_Dtack); else passed++;
    BusMode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (lookup_cfg !== 16'h0000) $display("FAIL reset_table5 got %h exp 0000", lookup_cfg); else passed++;
  endtask

  task automatic test_mode0_write_read();
    logic [15:0] rd;
    int ae, re;
    do_access(1'b0, 1'b1, 24'h000005, 16'h3ABC, rd, ae, re);
    checks++; if (ae !== ACK_EDGES) $display("FAIL m0_wr_ack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    checks++; if (re !== REL_EDGES) $display("FAIL m0_wr_rel_edges got %0d exp %0d", re, REL_EDGES); else passed++;
    do_access(1'b0, 1'b0, 24'h000005, 16'h0000, rd, ae, re);
    checks++; if (rd !== 16'h3ABC) $display("FAIL m0_rd_data got %h exp 3abc", rd); else passed++;
    checks++; if (ae !== ACK_EDGES) $display("FAIL m0_rd_ack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    lookup_idx = 8'd5;
    repeat (2) @(negedge clk);
    checks++; if (lookup_cfg !== 16'h3ABC) $display("FAIL m0_lookup5 got %h exp 3abc", lookup_cfg); else passed++;
    // Both strobes low is a write.
    start_access(1'b0, 1'b1, 24'h000014, 16'h00AA);
    Rd_DS = 1'b0;
    wait_ack(ae);
    release_bus(re);
    do_access(1'b0, 1'b0, 24'h000014, 16'h0000, rd, ae, re);
    checks++; if (rd !== 16'h00AA) $display("FAIL m0_both_strobes_wr got %h exp 00aa", rd); else passed++;
  endtask

  task automatic test_mode1_write_read();
    logic [15:0] rd;
    int ae, re;
    do_access(1'b1, 1'b1, 24'h0000FF, 16'h1234, rd, ae, re);
    checks++; if (ae !== ACK_EDGES) $display("FAIL m1_wr_dtack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    checks++; if (re !== REL_EDGES) $display("FAIL m1_wr_rel_edges got %0d exp %0d", re, REL_EDGES); else passed++;
    checks++; if (Rdy_Dtack !== 1'b1) $display("FAIL m1_idle_dtack got %b exp 1", Rdy_Dtack); else passed++;
    do_access(1'b1, 1'b0, 24'h0000FF, 16'h0000, rd, ae, re);
    checks++; if (rd !== 16'h1234) $display("FAIL m1_rd_data got %h exp 1234", rd); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd;
    int ae, re;
    do_access(1'b0, 1'b0, 24'h000100, 16'h0000, rd, ae, re);
    checks++; if (ae !== ACK_EDGES) $display("FAIL oor_rd_ack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    checks++; if (rd !== 16'h0000) $display("FAIL oor_rd_data got %h exp 0000", rd); else passed++;
    do_access(1'b0, 1'b1, 24'h000100, 16'hBEEF, rd, ae, re);
    checks++; if (ae !== ACK_EDGES) $display("FAIL oor_wr_ack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    do_access(1'b0, 1'b0, 24'h000000, 16'h0000, rd, ae, re);
    checks++; if (rd !== 16'h0000) $display("FAIL oor_wr_dropped got %h exp 0000", rd); else passed++;
  endtask

  task automatic test_lookup_collision();
    logic [15:0] rd;
    int ae, re;
    do_access(1'b0, 1'b1, 24'h000007, 16'h0042, rd, ae, re);
    lookup_idx = 8'd7;
    start_access(1'b0, 1'b1, 24'h000007, 16'hFFFF);
    wait_ack(ae);
    checks++; if (lookup_cfg !== 16'h0042) $display("FAIL lookup_same_edge got %h exp 0042", lookup_cfg); else passed++;
    @(negedge clk);
    checks++; if (lookup_cfg !== 16'hFFFF) $display("FAIL lookup_next_cycle got %h exp ffff", lookup_cfg); else passed++;
    release_bus(re);
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    int ae, re, drops;
    start_access(1'b0, 1'b1, 24'h00000C, 16'h1111);
    wait_ack(ae);
    DataIn = 16'h2222;
    Addr   = 24'h00000D;
    drops  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!ack_seen()) drops++;
    end
    checks++; if (drops !== 0) $display("FAIL held_ack_drops got %0d exp 0", drops); else passed++;
    release_bus(re);
    checks++; if (re !== REL_EDGES) $display("FAIL held_rel_edges got %0d exp %0d", re, REL_EDGES); else passed++;
    do_access(1'b0, 1'b0, 24'h00000C, 16'h0000, rd, ae, re);
    checks++; if (ae !== ACK_EDGES) $display("FAIL reassert_ack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    checks++; if (rd !== 16'h1111) $display("FAIL held_wr_data got %h exp 1111", rd); else passed++;
    do_access(1'b0, 1'b0, 24'h00000D, 16'h0000, rd, ae, re);
    checks++; if (rd !== 16'h0000) $display("FAIL held_no_second_wr got %h exp 0000", rd); else passed++;
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] rd;
    int ae, re, spurious;
    // Reset while an acknowledge is asserted: it must drop before any edge.
    start_access(1'b0, 1'b0, 24'h000005, 16'h0000);
    wait_ack(ae);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (Rdy_Dtack !== 1'b0) $display("FAIL rst_ack_async got %b exp 0", Rdy_Dtack); else passed++;
    checks++; if (DataOut !== 16'h0000) $display("FAIL rst_dataout got %h exp 0000", DataOut); else passed++;
    @(negedge clk);
    Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
    rst_n = 1'b1;
    // Reset during WAIT of a data-strobe write.
    start_access(1'b1, 1'b1, 24'h000009, 16'h5555);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (Rdy_Dtack !== 1'b1) $display("FAIL rst_wait_dtack got %b exp 1", Rdy_Dtack); else passed++;
    @(negedge clk);
    Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
    rst_n = 1'b1;
    spurious = 0;
    lookup_idx = 8'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack_seen()) spurious++;
    end
    checks++; if (spurious !== 0) $display("FAIL rst_spurious_ack got %0d exp 0", spurious); else passed++;
    checks++; if (lookup_cfg !== 16'h0000) $display("FAIL rst_entry9 got %h exp 0000", lookup_cfg); else passed++;
    do_access(1'b1, 1'b0, 24'h000009, 16'h0000, rd, ae, re);
    checks++; if (ae !== ACK_EDGES) $display("FAIL rst_idle_ack_edges got %0d exp %0d", ae, ACK_EDGES); else passed++;
    checks++; if (rd !== 16'h0000) $display("FAIL rst_rd9 got %h exp 0000", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_mode0_write_read();
    test_mode1_write_read();
    test_out_of_range();
    test_lookup_collision();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1);
  end

endmodule
